// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC zero-stuffing front end.
package cic_pkg;

    localparam int DEF_WIDTH_H = 5;
    localparam int DEF_WIDTH_W = 20;
    localparam int DEF_R_MAX   = 32;
    localparam int DEF_RW      = 6;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } zs_state_e;

    function automatic int dw(input int width_h, input int width_w);
        return width_h + width_w;
    endfunction

    // Zero means "no interpolation"; anything above the supported maximum saturates.
    function automatic int clamp_rate(input int rate, input int r_max);
        if (rate == 0) begin
            return 1;
        end else if (rate > r_max) begin
            return r_max;
        end else begin
            return rate;
        end
    endfunction

endpackage

// File: rtl/cic_pend_reg.sv
// Single-entry holding register; a load in the same cycle as an unload wins (refill).
module cic_pend_reg #(
    parameter int DW = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          unload_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Entry state: load takes priority so simultaneous load/unload keeps the entry full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cic_zero_stuffer.sv
// Rate expander feeding the CIC interpolator: each sample becomes R_eff beats.
// Define CIC_ZS_HOLD_EN for zero-order hold instead of zero stuffing.
module cic_zero_stuffer
    import cic_pkg::*;
#(
    parameter  int width_H = DEF_WIDTH_H,
    parameter  int width_W = DEF_WIDTH_W,
    parameter  int R_MAX   = DEF_R_MAX,
    parameter  int RW      = DEF_RW,
    localparam int DW      = dw(width_H, width_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rate_i,
    input  logic          data_i_en,
    input  logic [DW-1:0] data_i,
    output logic          data_i_rdy,
    output logic          data_o_en,
    output logic [DW-1:0] data_o,
    output logic          busy_o,
    output logic          underrun_o
);

`ifdef CIC_ZS_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    zs_state_e     state_q, state_d;
    logic [RW-1:0] phase_q, phase_d;
    logic [RW-1:0] r_eff_q, r_eff_d;
    logic [DW-1:0] samp_q, samp_d;
    logic          en_q, en_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          busy_q;
    logic          rdy_q, rdy_d;
    logic          armed_q, armed_d;
    logic          underrun_q, underrun_d;

    logic          pend_v_s;
    logic [DW-1:0] pend_data_s;
    logic [RW-1:0] r_clamp_s;
    logic          xfer_s, last_s, boundary_s;
    logic          consume_s, direct_s, start_s;
    logic          pend_load_s, pend_v_next_s;

    // A new burst can start only from IDLE or on the last phase of the current one;
    // the pending entry always has precedence over a sample arriving this cycle.
    assign xfer_s        = data_i_en && rdy_q;
    assign last_s        = (state_q == EMIT) && (phase_q == r_eff_q - RW'(1));
    assign boundary_s    = (state_q == IDLE) || last_s;
    assign consume_s     = boundary_s && pend_v_s;
    assign direct_s      = boundary_s && !pend_v_s && xfer_s;
    assign start_s       = consume_s || direct_s;
    assign pend_load_s   = xfer_s && !direct_s;
    assign pend_v_next_s = pend_load_s || (pend_v_s && !consume_s);
    assign r_clamp_s     = RW'(clamp_rate(int'(rate_i), R_MAX));

    cic_pend_reg #(
        .DW(DW)
    ) u_pend (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pend_load_s),
        .unload_i(consume_s),
        .data_i  (data_i),
        .valid_o (pend_v_s),
        .data_o  (pend_data_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_s ? EMIT : IDLE;
            EMIT:    state_d = (last_s && !start_s) ? IDLE : EMIT;
            default: state_d = IDLE;
        endcase

        phase_d = start_s ? '0 : ((state_q == EMIT) ? phase_q + RW'(1) : '0);
        r_eff_d = start_s ? r_clamp_s : r_eff_q;
        samp_d  = start_s ? (consume_s ? pend_data_s : data_i) : samp_q;

        en_d  = (state_d == EMIT);
        dat_d = (en_d && ((phase_d == '0) || HOLD)) ? samp_d : '0;

        // Ready next cycle if pend will be empty or will be drained on that cycle.
        rdy_d = !pend_v_next_s || (state_d == IDLE) || (phase_d == r_eff_d - RW'(1));

        // Underrun is reported one cycle after the first data_i_en that finds the stream dry.
        underrun_d = armed_q && (state_q == IDLE) && data_i_en;
        if ((state_q == EMIT) && (state_d == IDLE)) begin
            armed_d = 1'b1;
        end else if (underrun_d) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            r_eff_q    <= RW'(1);
            samp_q     <= '0;
            en_q       <= 1'b0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            armed_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            r_eff_q    <= r_eff_d;
            samp_q     <= samp_d;
            en_q       <= en_d;
            dat_q      <= dat_d;
            busy_q     <= (state_d == EMIT);
            rdy_q      <= rdy_d;
            armed_q    <= armed_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_i_rdy = rdy_q;
    assign data_o_en  = en_q;
    assign data_o     = dat_q;
    assign busy_o     = busy_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_cic_zero_stuffer.sv
// Scoreboard bench for cic_zero_stuffer: accepted samples expand into expected beat
// lists; an independent monitor pops one entry per valid output beat.
module tb_cic_zero_stuffer;

    localparam int DW   = 25;
    localparam int RW   = 6;
    localparam int RMAX = 32;
`ifdef CIC_ZS_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rate_i;
    logic          data_i_en;
    logic [DW-1:0] data_i;
    logic          data_i_rdy;
    logic          data_o_en;
    logic [DW-1:0] data_o;
    logic          busy_o;
    logic          underrun_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_rate;
    int run_len  = 0;
    int last_run = 0;
    logic [DW-1:0] exp_q[$];

    cic_zero_stuffer dut (
        .clk       (clk),
        .rst       (rst),
        .rate_i    (rate_i),
        .data_i_en (data_i_en),
        .data_i    (data_i),
        .data_i_rdy(data_i_rdy),
        .data_o_en (data_o_en),
        .data_o    (data_o),
        .busy_o    (busy_o),
        .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int eff_rate(input int r);
        if (r == 0) return 1;
        if (r > RMAX) return RMAX;
        return r;
    endfunction

    // Reference: one accepted sample becomes R beats, sample first then zeros (or repeats).
    task automatic push_burst(input logic [DW-1:0] s, input int r);
        for (int k = 0; k < r; k++) begin
            exp_q.push_back((k == 0 || HOLD) ? s : '0);
        end
    endtask

    // Rate is only changed while no accepted sample is still waiting to start,
    // so the rate seen at acceptance is the rate its burst uses.
    task automatic set_rate(input int r);
        cur_rate = r;
        rate_i   = RW'(r);
    endtask

    task automatic send(input logic [DW-1:0] s);
        bit done = 1'b0;
        data_i_en = 1'b1;
        data_i    = s;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (data_i_rdy) begin
                push_burst(s, eff_rate(cur_rate));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: sample %0h never accepted within 200 cycles", s);
        end
    endtask

    task automatic idle(input int n);
        data_i_en = 1'b0;
        data_i    = DW'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every valid beat must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len = 0;
            end else if (data_o_en) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", data_o);
                end else begin
                    check("beat", 32'(data_o), 32'(exp_q.pop_front()));
                end
            end else begin
                check("idle_data_zero", 32'(data_o), 32'd0);
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        data_i_en = 1'b0;
        data_i    = '0;
        set_rate(4);
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", 32'(data_o_en), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_rdy", 32'(data_i_rdy), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 32'(data_i_rdy), 32'd1);

        // Single sample at R=4, then an underrun on the next arrival.
        send(25'h0_0123);
        check("no_underrun_first", 32'(underrun_o), 32'd0);
        check("busy_in_burst", 32'(busy_o), 32'd1);
        idle(8);
        check("run_r4", 32'(last_run), 32'd4);
        check("busy_idle", 32'(busy_o), 32'd0);
        send(25'h0_0042);
        check("underrun_pulse", 32'(underrun_o), 32'd1);
        idle(1);
        check("underrun_one_cycle", 32'(underrun_o), 32'd0);
        idle(8);

        // Back-to-back at R=3 must give one contiguous 9-beat run.
        set_rate(3);
        send(25'd10);
        send(25'd20);
        send(25'd30);
        idle(14);
        check("run_b2b_r3", 32'(last_run), 32'd9);

        // Rate clamping boundaries.
        set_rate(0);
        send(DW'($urandom));
        idle(4);
        check("run_r0", 32'(last_run), 32'd1);
        send(DW'($urandom));
        send(DW'($urandom));
        send(DW'($urandom));
        idle(4);
        check("run_r0_stream", 32'(last_run), 32'd3);
        set_rate(40);
        send(DW'($urandom));
        idle(40);
        check("run_r40", 32'(last_run), 32'd32);

        // Rate change during phase 2: current burst keeps 4, next uses 2.
        set_rate(4);
        send(25'h0_0123);
        idle(2);
        set_rate(2);
        send(25'h0_0456);
        idle(10);
        check("run_rate_change", 32'(last_run), 32'd6);

        // Reset mid-burst with pending full drops both samples.
        set_rate(4);
        send(25'h1_1111);
        send(25'h0_2222);
        rst       = 1'b1;
        data_i_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_en", 32'(data_o_en), 32'd0);
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_rdy", 32'(data_i_rdy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rdy_after", 32'(data_i_rdy), 32'd1);
        idle(40);
        send(25'h0_0777);
        check("no_underrun_after_rst", 32'(underrun_o), 32'd0);
        idle(8);

        // Negative sample at R=3.
        set_rate(3);
        send(-25'sd5);
        idle(6);

        // Randomized segments; rate only changes once the pipeline has drained.
        for (int seg = 0; seg < 6; seg++) begin
            set_rate(int'($urandom_range(0, 40)));
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
                send(DW'($urandom));
            end
            idle(3 * RMAX + 8);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
